// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared pipeline types for the instruction queue
package inst_queue_pkg;

    localparam int INST_QUEUE_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } inst_t;

endpackage

// File: rtl/inst_queue_ram.sv
// rtl/inst_queue_ram.sv - DEPTH-entry 2W/2R register array, combinational reads
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  inst_t         wdata0,
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  inst_t         wdata1,
    input  logic [AW-1:0] raddr0,
    output inst_t         rdata0,
    input  logic [AW-1:0] raddr1,
    output inst_t         rdata1
);

    inst_t mem [DEPTH];

    // Storage is deliberately not reset; validity is tracked by the control logic.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - dual-issue instruction queue; optional perf counters via INST_QUEUE_PERF_CNT_EN
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  inst_t [1:0]              in_inst_i,
    input  logic [1:0]               in_valid_i,
    output logic                     in_ready_o,
    output inst_t [1:0]              out_inst_o,
    output logic [1:0]               out_valid_o,
    input  logic [1:0]               issue_num_i,
    output logic [$clog2(DEPTH):0]   count_o
`ifdef INST_QUEUE_PERF_CNT_EN
    ,
    output logic [31:0]              perf_empty_cnt_o,
    output logic [31:0]              perf_full_cnt_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic [1:0]       req_n;
    logic [1:0]       push_n;
    logic [1:0]       issue_n;
    logic [1:0]       avail_n;
    logic [1:0]       pop_n;

    // Ready looks only at registered count so there is no ready-from-issue path.
    assign in_ready_o  = (count <= (PTR_W+1)'(DEPTH - 2));
    assign out_valid_o = {count >= (PTR_W+1)'(2), count != '0};
    assign count_o     = count;

    always_comb begin
        req_n   = 2'd0;
        push_n  = 2'd0;
        issue_n = 2'd0;
        avail_n = 2'd0;
        pop_n   = 2'd0;
        if (in_valid_i == 2'b11) begin
            req_n = 2'd2;
        end else if (in_valid_i == 2'b01) begin
            req_n = 2'd1;
        end
        if (in_ready_o && !flush_i) begin
            push_n = req_n;
        end
        if (issue_num_i != 2'd3) begin
            issue_n = issue_num_i;
        end
        avail_n = out_valid_o[1] ? 2'd2 : {1'b0, out_valid_o[0]};
        if (!flush_i) begin
            pop_n = (issue_n > avail_n) ? avail_n : issue_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + (PTR_W+1)'(push_n) - (PTR_W+1)'(pop_n);
        end
    end

    inst_queue_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we0    (push_n != 2'd0),
        .waddr0 (tail),
        .wdata0 (in_inst_i[0]),
        .we1    (push_n == 2'd2),
        .waddr1 (tail + PTR_W'(1)),
        .wdata1 (in_inst_i[1]),
        .raddr0 (head),
        .rdata0 (out_inst_o[0]),
        .raddr1 (head + PTR_W'(1)),
        .rdata1 (out_inst_o[1])
    );

`ifdef INST_QUEUE_PERF_CNT_EN
    // Counters survive flush so software sees totals across redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_empty_cnt_o <= '0;
            perf_full_cnt_o  <= '0;
        end else begin
            if (count == '0 && !flush_i) begin
                perf_empty_cnt_o <= perf_empty_cnt_o + 32'd1;
            end
            if (!in_ready_o && in_valid_i != 2'b00) begin
                perf_full_cnt_o <= perf_full_cnt_o + 32'd1;
            end
        end
    end
`endif

    a_in_valid_legal: assert property (@(posedge clk) disable iff (rst)
        in_valid_i != 2'b10);
    a_issue_num_legal: assert property (@(posedge clk) disable iff (rst)
        issue_num_i != 2'd3);
    a_issue_not_over: assert property (@(posedge clk) disable iff (rst)
        issue_num_i == 2'd3 || issue_num_i <= avail_n);

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized self-checking bench for inst_queue against a queue model
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    inst_t [1:0] in_inst;
    logic [1:0]  in_valid;
    logic        in_ready;
    inst_t [1:0] out_inst;
    logic [1:0]  out_valid;
    logic [1:0]  issue_num;
    logic [3:0]  count;
`ifdef INST_QUEUE_PERF_CNT_EN
    logic [31:0] perf_empty;
    logic [31:0] perf_full;
    int          exp_empty;
    int          exp_full;
`endif

    int    checks = 0;
    int    failures = 0;
    int    seq = 0;
    inst_t q[$];
    inst_t last0, last1;
    inst_t a_i, b_i, c_i, d_i;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_inst_i   (in_inst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_inst_o  (out_inst),
        .out_valid_o (out_valid),
        .issue_num_i (issue_num),
        .count_o     (count)
`ifdef INST_QUEUE_PERF_CNT_EN
        ,
        .perf_empty_cnt_o (perf_empty),
        .perf_full_cnt_o  (perf_full)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compare_outputs();
        logic [1:0] ev;
        ev = {q.size() >= 2, q.size() >= 1};
        check("count", 64'(count), 64'(q.size()));
        check("ready", 64'(in_ready), 64'((DEPTH - q.size()) >= 2));
        check("valid", 64'(out_valid), 64'(ev));
        if (q.size() >= 1) check("out0", out_inst[0], q[0]);
        if (q.size() >= 2) check("out1", out_inst[1], q[1]);
`ifdef INST_QUEUE_PERF_CNT_EN
        check("perf_empty", 64'(perf_empty), 64'(exp_empty));
        check("perf_full", 64'(perf_full), 64'(exp_full));
`endif
    endtask

    task automatic model_update();
        bit ready;
        int n;
        ready = (DEPTH - q.size()) >= 2;
`ifdef INST_QUEUE_PERF_CNT_EN
        if (q.size() == 0 && !flush) exp_empty++;
        if (!ready && in_valid != 2'b00) exp_full++;
`endif
        if (flush) begin
            q.delete();
        end else begin
            n = (issue_num == 2'd3) ? 0 : int'(issue_num);
            if (n > q.size()) n = q.size();
            for (int i = 0; i < n; i++) void'(q.pop_front());
            if (ready && in_valid == 2'b11) begin
                q.push_back(in_inst[0]);
                q.push_back(in_inst[1]);
            end else if (ready && in_valid == 2'b01) begin
                q.push_back(in_inst[0]);
            end
        end
    endtask

    task automatic step();
        compare_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic next_inst(output inst_t x);
        seq++;
        x.pc   = 32'(seq);
        x.insn = $urandom;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] iss, input logic fl);
        next_inst(last0);
        next_inst(last1);
        in_inst[0] = last0;
        in_inst[1] = last1;
        in_valid   = v;
        issue_num  = iss;
        flush      = fl;
        step();
    endtask

    function automatic logic [1:0] max_issue();
        return (q.size() >= 2) ? 2'd2 : 2'(q.size());
    endfunction

    task automatic drain();
        for (int i = 0; i < DEPTH && q.size() > 0; i++) drive(2'b00, max_issue(), 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 2'b00;
        issue_num = 2'd0;
        in_inst = '0;
`ifdef INST_QUEUE_PERF_CNT_EN
        exp_empty = 0;
        exp_full = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // fill to full; fifth push must be refused
        for (int i = 0; i < 5; i++) drive(2'b11, 2'd0, 1'b0);
        check("full_count", 64'(count), 64'd8);
        check("full_ready", 64'(in_ready), 64'd0);
`ifdef INST_QUEUE_PERF_CNT_EN
        check("perf_full1", 64'(perf_full), 64'd1);
`endif
        drain();

        // A,B,C,D then issue 2 and 1
        drive(2'b11, 2'd0, 1'b0); a_i = last0; b_i = last1;
        drive(2'b11, 2'd0, 1'b0); c_i = last0; d_i = last1;
        drive(2'b00, 2'd2, 1'b0);
        check("abcd_out0", out_inst[0], c_i);
        check("abcd_out1", out_inst[1], d_i);
        check("abcd_valid", 64'(out_valid), 64'b11);
        drive(2'b00, 2'd1, 1'b0);
        check("abcd_valid1", 64'(out_valid), 64'b01);
        check("abcd_d", out_inst[0], d_i);
        drain();

        // steady state at count 4 across pointer wrap
        drive(2'b11, 2'd0, 1'b0);
        drive(2'b11, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++) drive(2'b11, 2'd2, 1'b0);
        check("steady_count", 64'(count), 64'd4);
        drain();

        // push and pop in the same cycle
        drive(2'b01, 2'd0, 1'b0);
        drive(2'b11, 2'd1, 1'b0); b_i = last0; c_i = last1;
        check("pp_count", 64'(count), 64'd2);
        check("pp_out0", out_inst[0], b_i);
        check("pp_out1", out_inst[1], c_i);
        drain();

        // flush discards same-cycle push and pop
        for (int i = 0; i < 3; i++) drive(2'b11, 2'd0, 1'b0);
        drive(2'b11, 2'd2, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        drive(2'b01, 2'd0, 1'b0); a_i = last0;
        check("flush_out0", out_inst[0], a_i);
        check("flush_idx0", dut.u_ram.mem[0], a_i);
        drain();

        // asynchronous reset mid-cycle at count 5
        drive(2'b11, 2'd0, 1'b0);
        drive(2'b11, 2'd0, 1'b0);
        drive(2'b01, 2'd0, 1'b0);
        check("pre_arst_count", 64'(count), 64'd5);
        in_valid = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 64'(count), 64'd0);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready), 64'd1);
        q.delete();
`ifdef INST_QUEUE_PERF_CNT_EN
        exp_empty = 0;
        exp_full = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) drive(2'b00, 2'd0, 1'b0);
`ifdef INST_QUEUE_PERF_CNT_EN
        check("perf_empty10", 64'(perf_empty), 64'd10);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] v;
            logic [1:0] iss;
            case ($urandom_range(0, 2))
                0: v = 2'b00;
                1: v = 2'b01;
                default: v = 2'b11;
            endcase
            iss = 2'($urandom_range(0, int'(max_issue())));
            drive(v, iss, ($urandom_range(0, 24) == 0));
        end
        in_valid = 2'b00;
        issue_num = 2'd0;
        flush = 1'b0;
        compare_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
